// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: access sizes, FSM states
// and the pipeline data width.
package data_mem_responder_pkg;

    localparam int DMEM_DWIDTH = 32;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data,
// lane extraction with sign/zero extension, and alignment checking.
module dmem_lane_align
    import data_mem_responder_pkg::*;
#(
    parameter int DWIDTH = DMEM_DWIDTH
) (
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [DWIDTH-1:0] raw,
    output logic [3:0]        byte_en,
    output logic [DWIDTH-1:0] wdata_lane,
    output logic [DWIDTH-1:0] rdata_ext,
    output logic              misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte    = raw[8*addr_lo +: 8];
        rd_half    = addr_lo[1] ? raw[31:16] : raw[15:0];
        byte_en    = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = raw;
        misalign   = 1'b0;
        // Store data is replicated across lanes; the byte enables pick the live one.
        case (size)
            MEM_SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = is_unsigned ? {{(DWIDTH-8){1'b0}}, rd_byte}
                                         : {{(DWIDTH-8){rd_byte[7]}}, rd_byte};
            end
            MEM_SIZE_HALF: begin
                byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = is_unsigned ? {{(DWIDTH-16){1'b0}}, rd_half}
                                         : {{(DWIDTH-16){rd_half[15]}}, rd_half};
                misalign   = addr_lo[0];
            end
            MEM_SIZE_WORD: begin
                byte_en  = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for the MEM stage: valid/ready request,
// fixed access latency, one-cycle response strobe, busy for hazard stalls.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DWIDTH  = DMEM_DWIDTH,
    parameter int AWIDTH  = 10,
    parameter int LATENCY = 2
) (
    input  logic              d_clk,
    input  logic              d_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    dmem_state_e       state;
    logic [3:0]        cnt;
    logic              cap_we;
    logic [1:0]        cap_size;
    logic              cap_unsigned;
    logic [AWIDTH+1:0] cap_addr;
    logic [DWIDTH-1:0] cap_wdata;
    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

    logic [1:0]        align_size;
    logic [1:0]        align_lo;
    logic [3:0]        byte_en;
    logic [DWIDTH-1:0] wdata_lane;
    logic [DWIDTH-1:0] rdata_ext;
    logic [DWIDTH-1:0] raw;
    logic              misalign;
    logic              access;
    logic              unused_addr;

    // Upper address bits are dropped so addresses wrap around the array.
    assign unused_addr = ^req_addr[31:AWIDTH+2];

    // Alignment is judged on the live request while idle, on the captured one afterwards.
    assign align_size = req_ready ? req_size       : cap_size;
    assign align_lo   = req_ready ? req_addr[1:0]  : cap_addr[1:0];
    assign raw        = mem[cap_addr[AWIDTH+1:2]];
    assign access     = (state == WAIT) && (cnt == 4'd0);

    dmem_lane_align #(
        .DWIDTH(DWIDTH)
    ) u_align (
        .size       (align_size),
        .addr_lo    (align_lo),
        .is_unsigned(cap_unsigned),
        .wdata      (cap_wdata),
        .raw        (raw),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign)
    );

    always_ff @(posedge d_clk) begin
        if (req_ready && req_valid) begin
            cap_we       <= req_we;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_addr     <= req_addr[AWIDTH+1:0];
            cap_wdata    <= req_wdata;
        end
    end

    always_ff @(posedge d_clk) begin
        if (access && cap_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[cap_addr[AWIDTH+1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (misalign) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= cap_we ? '0 : rdata_ext;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance a at LATENCY=2, instance b at LATENCY=3, sharing
// clock, reset and request fields but with separate request valids.
module tb_data_mem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 3;

    logic        d_clk;
    logic        d_rst;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        valid_a, ready_a, resp_valid_a, resp_err_a, busy_a;
    logic [31:0] resp_rdata_a;
    logic        valid_b, ready_b, resp_valid_b, resp_err_b, busy_b;
    logic [31:0] resp_rdata_b;

    int total = 0;
    int fails = 0;

    data_mem_responder #(.DWIDTH(32), .AWIDTH(10), .LATENCY(LAT_A)) dut_a (
        .d_clk(d_clk), .d_rst(d_rst),
        .req_valid(valid_a), .req_ready(ready_a),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a),
        .resp_err(resp_err_a), .busy(busy_a)
    );

    data_mem_responder #(.DWIDTH(32), .AWIDTH(10), .LATENCY(LAT_B)) dut_b (
        .d_clk(d_clk), .d_rst(d_rst),
        .req_valid(valid_b), .req_ready(ready_b),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
        .resp_err(resp_err_b), .busy(busy_b)
    );

    initial d_clk = 1'b0;
    always #5 d_clk = ~d_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One request on instance a; inputs are scrambled right after acceptance.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge d_clk);
        check1("ready_before", ready_a, 1'b1);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; valid_a = 1'b1;
        @(posedge d_clk);
        #1;
        valid_a = 1'b0;
        req_we = ~we; req_size = 2'b11; req_unsigned = ~uns;
        req_addr = ~addr; req_wdata = ~wd;
        lat = 0; rd = '0; er = 1'b0;
        while (lat < 20) begin
            @(negedge d_clk);
            lat++;
            if (lat == 1) check1("busy_in_flight", busy_a, 1'b1);
            if (resp_valid_a) begin
                rd = resp_rdata_a;
                er = resp_err_a;
                break;
            end
        end
        @(negedge d_clk);
        check1("valid_drop", resp_valid_a, 1'b0);
        check1("ready_after", ready_a, 1'b1);
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(we, size, uns, addr, wd, rd, er, lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check1({tag, "_err"}, er, exp_err);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic seen;
        valid_a = 1'b0; valid_b = 1'b0;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        d_rst = 1'b1;
        #2 d_rst = 1'b0;
        repeat (3) @(negedge d_clk);
        check1("rst_ready", ready_a, 1'b1);
        check1("rst_busy", busy_a, 1'b0);
        check1("rst_valid", resp_valid_a, 1'b0);
        check1("rst_err", resp_err_a, 1'b0);
        check("rst_rdata", resp_rdata_a, 32'h0);
        check1("rst_ready_b", ready_b, 1'b1);
        d_rst = 1'b1;

        // Word store then load, latency LAT_A+1 negedges after acceptance edge.
        run("st_w40",  1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0,        1'b0, LAT_A + 1);
        run("ld_w40",  1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0, LAT_A + 1);
        run("ld_b43s", 1'b0, 2'b00, 1'b0, 32'h43, 32'h0,        32'hFFFFFFDE, 1'b0, LAT_A + 1);
        run("ld_b43u", 1'b0, 2'b00, 1'b1, 32'h43, 32'h0,        32'h000000DE, 1'b0, LAT_A + 1);
        run("ld_h40s", 1'b0, 2'b01, 1'b0, 32'h40, 32'h0,        32'hFFFFBEEF, 1'b0, LAT_A + 1);
        run("ld_h42u", 1'b0, 2'b01, 1'b1, 32'h42, 32'h0,        32'h0000DEAD, 1'b0, LAT_A + 1);

        // Byte store touches one lane only; upper wdata bits must be ignored.
        run("st_b41",  1'b1, 2'b00, 1'b0, 32'h41, 32'hFFFFFF5A, 32'h0,        1'b0, LAT_A + 1);
        run("ld_w40b", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'hDEAD5AEF, 1'b0, LAT_A + 1);

        // Misaligned and reserved-size requests respond after one edge.
        run("err_h41", 1'b0, 2'b01, 1'b0, 32'h41, 32'h0,        32'h0,        1'b1, 1);
        run("err_w42", 1'b1, 2'b10, 1'b0, 32'h42, 32'h12345678, 32'h0,        1'b1, 1);
        run("err_sz3", 1'b1, 2'b11, 1'b0, 32'h40, 32'h87654321, 32'h0,        1'b1, 1);
        run("ld_w40c", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'hDEAD5AEF, 1'b0, LAT_A + 1);

        // Instance b: two back-to-back requests with valid held high.
        @(negedge d_clk);
        check1("b_ready0", ready_b, 1'b1);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h1000; req_wdata = 32'hCAFEF00D; valid_b = 1'b1;
        @(posedge d_clk);
        #1;
        req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 1; i <= LAT_B + 1; i++) begin
            @(negedge d_clk);
            check1("b1_ready_low", ready_b, 1'b0);
            check1("b1_busy", busy_b, 1'b1);
            check1("b1_resp_valid", resp_valid_b, (i == LAT_B + 1));
        end
        check("b1_rdata", resp_rdata_b, 32'h0);
        check1("b1_err", resp_err_b, 1'b0);
        @(negedge d_clk);
        check1("b1_ready_back", ready_b, 1'b1);
        check1("b1_valid_drop", resp_valid_b, 1'b0);
        @(posedge d_clk);
        #1;
        valid_b = 1'b0;
        for (int i = 1; i <= LAT_B + 1; i++) begin
            @(negedge d_clk);
            check1("b2_ready_low", ready_b, 1'b0);
            check1("b2_resp_valid", resp_valid_b, (i == LAT_B + 1));
        end
        check("b2_alias_rdata", resp_rdata_b, 32'hCAFEF00D);
        @(negedge d_clk);
        check1("b2_ready_back", ready_b, 1'b1);

        // Reset during an in-flight store discards it.
        run("st_w80", 1'b1, 2'b10, 1'b0, 32'h80, 32'h0BADF00D, 32'h0, 1'b0, LAT_A + 1);
        @(negedge d_clk);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h80; req_wdata = 32'h11111111; valid_a = 1'b1;
        @(posedge d_clk);
        #1;
        valid_a = 1'b0;
        @(negedge d_clk);
        check1("mid_busy_pre", busy_a, 1'b1);
        d_rst = 1'b0;
        #1;
        check1("mid_rst_busy", busy_a, 1'b0);
        check1("mid_rst_ready", ready_a, 1'b1);
        check1("mid_rst_valid", resp_valid_a, 1'b0);
        @(negedge d_clk);
        d_rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge d_clk);
            if (resp_valid_a) seen = 1'b1;
        end
        check1("mid_no_resp", seen, 1'b0);
        run("ld_w80", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0BADF00D, 1'b0, LAT_A + 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
